// File: rtl/combo_lock_pkg.sv
// Shared definitions for the combination lock controller.
//   state_t     : controller FSM states
//   DIGITS_DEF  : default number of digits per code
//   DIGIT_W_DEF : default width of one keypad digit
package combo_lock_pkg;

  localparam int DIGITS_DEF  = 4;
  localparam int DIGIT_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,     // waiting for the first digit
    ENTRY,    // collecting the remaining digits
    CHECK,    // one cycle, evaluates the entry
    FAIL,     // one cycle, reports a rejection
    OPEN,     // lock open, timed
    LOCKOUT   // keypad disabled, timed
  } state_t;

endpackage

// File: rtl/digit_pos_counter.sv
// Wrapping digit-position counter for the combination lock.
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous, active-low reset
//   inc  in   advance to the next digit position
//   clr  in   return to position 0 (wins over inc)
//   pos  out  index of the next digit expected
//   last out  pos is the final digit position (DIGITS-1)
module digit_pos_counter
  import combo_lock_pkg::*;
#(
  parameter int  DIGITS = DIGITS_DEF,
  localparam int PW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [PW-1:0] pos,
  output logic          last
);

  assign last = (pos == PW'(DIGITS - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of always-block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (inc) begin
      pos <= last ? '0 : pos + PW'(1);
    end
  end

endmodule

// File: rtl/combo_lock_ctrl.sv
// Sequencing controller for the combination lock: accepts one digit per
// strobe, compares the complete entry against CODE and drives the unlock,
// rejection and lockout indications.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous, active-low reset
//   key_valid  in   one-cycle strobe, digit present on key_digit
//   key_digit  in   digit value
//   relock     in   level; closes the lock or aborts a partial entry
//   pos        out  index of the next digit expected
//   unlocked   out  lock open
//   fail_pulse out  one-cycle pulse per rejected entry
//   lockout    out  keypad locked out
//   fail_cnt   out  consecutive failed entries
module combo_lock_ctrl
  import combo_lock_pkg::*;
#(
  parameter int                        DIGITS         = DIGITS_DEF,
  parameter int                        DIGIT_W        = DIGIT_W_DEF,
  parameter logic [DIGITS*DIGIT_W-1:0] CODE           = 16'h4321,
  parameter int                        MAX_FAILS      = 3,
  parameter int                        OPEN_CYCLES    = 16,
  parameter int                        LOCKOUT_CYCLES = 64,
  localparam int                       PW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int                       FW = $clog2(MAX_FAILS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               relock,
  output logic [PW-1:0]      pos,
  output logic               unlocked,
  output logic               fail_pulse,
  output logic               lockout,
  output logic [FW-1:0]      fail_cnt
);

  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  state_t             state, state_d;
  logic               mismatch, mismatch_d;
  logic [FW-1:0]      fail_cnt_d, fail_inc;
  logic [TW-1:0]      timer, timer_d;
  logic               cnt_inc, cnt_clr, last;
  logic [DIGIT_W-1:0] code_digit;

  digit_pos_counter #(.DIGITS(DIGITS)) u_pos (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .pos  (pos),
    .last (last)
  );

  assign code_digit = CODE[int'(pos) * DIGIT_W +: DIGIT_W];
  assign fail_inc   = fail_cnt + FW'(1);

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    mismatch_d = mismatch;
    fail_cnt_d = fail_cnt;
    timer_d    = timer;
    cnt_inc    = 1'b0;
    cnt_clr    = 1'b0;
    unique case (state)
      IDLE, ENTRY: begin
        if (relock) begin
          cnt_clr    = 1'b1;
          mismatch_d = 1'b0;
          state_d    = IDLE;
        end else if (key_valid) begin
          cnt_inc = 1'b1;
          // Sticky flag: a wrong digit is only reported once the full entry
          // is in, so the lock never reveals which position was wrong.
          if (key_digit != code_digit) mismatch_d = 1'b1;
          state_d = last ? CHECK : ENTRY;
        end
      end
      CHECK: begin
        mismatch_d = 1'b0;
        if (!mismatch) begin
          fail_cnt_d = '0;
          timer_d    = TW'(OPEN_CYCLES);
          state_d    = OPEN;
        end else begin
          fail_cnt_d = fail_inc;
          if (fail_inc == FW'(MAX_FAILS)) begin
            timer_d = TW'(LOCKOUT_CYCLES);
            state_d = LOCKOUT;
          end else begin
            state_d = FAIL;
          end
        end
      end
      FAIL: state_d = IDLE;
      OPEN: begin
        if (relock || timer == TW'(1)) state_d = IDLE;
        else                           timer_d = timer - TW'(1);
      end
      LOCKOUT: begin
        if (timer == TW'(1)) begin
          fail_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          timer_d = timer - TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change in step with
  // the state register and carry no decode glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      mismatch   <= 1'b0;
      fail_cnt   <= '0;
      timer      <= '0;
      unlocked   <= 1'b0;
      fail_pulse <= 1'b0;
      lockout    <= 1'b0;
    end else begin
      state      <= state_d;
      mismatch   <= mismatch_d;
      fail_cnt   <= fail_cnt_d;
      timer      <= timer_d;
      unlocked   <= (state_d == OPEN);
      fail_pulse <= (state_d == FAIL);
      lockout    <= (state_d == LOCKOUT);
    end
  end

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed testbench for combo_lock_ctrl with the default parameters
// (code 1,2,3,4; 3 failures to lockout; 16 open cycles; 64 lockout cycles).
module tb_combo_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = '0;
  logic       relock = 1'b0;
  logic [1:0] pos;
  logic       unlocked, fail_pulse, lockout;
  logic [1:0] fail_cnt;

  int checks = 0;
  int errors = 0;

  combo_lock_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .relock     (relock),
    .pos        (pos),
    .unlocked   (unlocked),
    .fail_pulse (fail_pulse),
    .lockout    (lockout),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  // Outputs are inspected 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    step();
    key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] a, b, c, d);
    key(a); key(b); key(c); key(d);
  endtask

  task automatic close_lock();
    relock = 1'b1;
    step();
    relock = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({pos, unlocked, fail_pulse, lockout, fail_cnt} !== 7'b0) begin
      errors++;
      $display("FAIL reset_state pos=%0d unl=%b fp=%b lo=%b fc=%0d exp all 0",
               pos, unlocked, fail_pulse, lockout, fail_cnt);
    end
    #1 rst = 1'b1;
    step();
  endtask

  task automatic test_correct_entry();
    logic [3:0] digits [4];
    logic [1:0] exp_pos [4];
    digits  = '{4'd1, 4'd2, 4'd3, 4'd4};
    exp_pos = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      key(digits[i]);
      checks++;
      if (pos !== exp_pos[i] || unlocked !== 1'b0) begin
        errors++;
        $display("FAIL correct_pos i=%0d pos=%0d unl=%b exp pos=%0d unl=0", i, pos, unlocked, exp_pos[i]);
      end
    end
    for (int c = 1; c <= 16; c++) begin
      step();
      checks++;
      if (unlocked !== 1'b1 || fail_cnt !== 2'd0) begin
        errors++;
        $display("FAIL open_hold cycle=%0d unl=%b fc=%0d exp unl=1 fc=0", c, unlocked, fail_cnt);
      end
    end
    step();
    checks++;
    if (unlocked !== 1'b0) begin
      errors++;
      $display("FAIL open_expire unl=%b exp 0", unlocked);
    end
  endtask

  task automatic test_wrong_first();
    logic [3:0] digits [4];
    digits = '{4'd9, 4'd2, 4'd3, 4'd4};
    for (int i = 0; i < 4; i++) begin
      key(digits[i]);
      checks++;
      if (fail_pulse !== 1'b0 || unlocked !== 1'b0) begin
        errors++;
        $display("FAIL early_reject i=%0d fp=%b unl=%b exp fp=0 unl=0", i, fail_pulse, unlocked);
      end
    end
    step();
    checks++;
    if (fail_pulse !== 1'b1 || fail_cnt !== 2'd1 || unlocked !== 1'b0) begin
      errors++;
      $display("FAIL wrong_reject fp=%b fc=%0d unl=%b exp fp=1 fc=1 unl=0", fail_pulse, fail_cnt, unlocked);
    end
    step();
    checks++;
    if (fail_pulse !== 1'b0 || unlocked !== 1'b0) begin
      errors++;
      $display("FAIL fail_pulse_width fp=%b unl=%b exp fp=0 unl=0", fail_pulse, unlocked);
    end
    // A correct entry after a failure clears the failure count.
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    step();
    checks++;
    if (unlocked !== 1'b1 || fail_cnt !== 2'd0) begin
      errors++;
      $display("FAIL success_clears_fc unl=%b fc=%0d exp unl=1 fc=0", unlocked, fail_cnt);
    end
    close_lock();
  endtask

  task automatic test_lockout();
    enter4(4'd1, 4'd2, 4'd3, 4'd5);
    step();
    checks++;
    if (fail_pulse !== 1'b1 || fail_cnt !== 2'd1 || lockout !== 1'b0) begin
      errors++;
      $display("FAIL lockout_fail1 fp=%b fc=%0d lo=%b exp fp=1 fc=1 lo=0", fail_pulse, fail_cnt, lockout);
    end
    step();
    enter4(4'd5, 4'd5, 4'd5, 4'd5);
    step();
    checks++;
    if (fail_pulse !== 1'b1 || fail_cnt !== 2'd2 || lockout !== 1'b0) begin
      errors++;
      $display("FAIL lockout_fail2 fp=%b fc=%0d lo=%b exp fp=1 fc=2 lo=0", fail_pulse, fail_cnt, lockout);
    end
    step();
    enter4(4'd0, 4'd2, 4'd3, 4'd4);
    step();
    checks++;
    if (lockout !== 1'b1 || fail_cnt !== 2'd3 || fail_pulse !== 1'b0) begin
      errors++;
      $display("FAIL lockout_enter lo=%b fc=%0d fp=%b exp lo=1 fc=3 fp=0", lockout, fail_cnt, fail_pulse);
    end
    // Lockout cycles 2..5: digits and relock must both be ignored.
    relock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      key(4'(i + 1));
      checks++;
      if (lockout !== 1'b1 || pos !== 2'd0 || unlocked !== 1'b0) begin
        errors++;
        $display("FAIL lockout_ignore i=%0d lo=%b pos=%0d unl=%b exp lo=1 pos=0 unl=0", i, lockout, pos, unlocked);
      end
    end
    relock = 1'b0;
    for (int c = 6; c <= 64; c++) begin
      step();
      checks++;
      if (lockout !== 1'b1 || fail_cnt !== 2'd3) begin
        errors++;
        $display("FAIL lockout_hold cycle=%0d lo=%b fc=%0d exp lo=1 fc=3", c, lockout, fail_cnt);
      end
    end
    step();
    checks++;
    if (lockout !== 1'b0 || fail_cnt !== 2'd0) begin
      errors++;
      $display("FAIL lockout_exit lo=%b fc=%0d exp lo=0 fc=0", lockout, fail_cnt);
    end
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    step();
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL unlock_after_lockout unl=%b exp 1", unlocked);
    end
    close_lock();
  endtask

  task automatic test_abort();
    key(4'd1);
    key(4'd2);
    relock    = 1'b1;
    key_valid = 1'b1;
    key_digit = 4'd3;
    step();
    relock    = 1'b0;
    key_valid = 1'b0;
    checks++;
    if (pos !== 2'd0 || fail_pulse !== 1'b0) begin
      errors++;
      $display("FAIL abort_pos pos=%0d fp=%b exp pos=0 fp=0", pos, fail_pulse);
    end
    step();
    checks++;
    if (fail_pulse !== 1'b0 || fail_cnt !== 2'd0) begin
      errors++;
      $display("FAIL abort_no_fail fp=%b fc=%0d exp fp=0 fc=0", fail_pulse, fail_cnt);
    end
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    step();
    checks++;
    if (unlocked !== 1'b1) begin
      errors++;
      $display("FAIL abort_then_unlock unl=%b exp 1", unlocked);
    end
  endtask

  // Continues from the OPEN state left by test_abort (open cycle 1).
  task automatic test_early_relock();
    for (int i = 0; i < 3; i++) begin
      key(4'(i + 1));
      checks++;
      if (unlocked !== 1'b1 || pos !== 2'd0) begin
        errors++;
        $display("FAIL open_keys_ignored i=%0d unl=%b pos=%0d exp unl=1 pos=0", i, unlocked, pos);
      end
    end
    step();
    relock = 1'b1;
    step();
    relock = 1'b0;
    checks++;
    if (unlocked !== 1'b0 || pos !== 2'd0) begin
      errors++;
      $display("FAIL early_relock unl=%b pos=%0d exp unl=0 pos=0", unlocked, pos);
    end
    key(4'd4);
    checks++;
    if (pos !== 2'd1) begin
      errors++;
      $display("FAIL fresh_entry pos=%0d exp 1", pos);
    end
    close_lock();
  endtask

  task automatic test_reset_mid_entry();
    key(4'd1);
    key(4'd2);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({pos, unlocked, fail_pulse, lockout, fail_cnt} !== 7'b0) begin
      errors++;
      $display("FAIL async_reset_entry pos=%0d unl=%b fp=%b lo=%b fc=%0d exp all 0",
               pos, unlocked, fail_pulse, lockout, fail_cnt);
    end
    rst = 1'b1;
    key(4'd3);
    key(4'd4);
    step();
    step();
    checks++;
    if (unlocked !== 1'b0 || pos !== 2'd2 || fail_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset_discards unl=%b pos=%0d fp=%b exp unl=0 pos=2 fp=0", unlocked, pos, fail_pulse);
    end
    close_lock();
    // Reset while open drops the lock without waiting for an edge.
    enter4(4'd1, 4'd2, 4'd3, 4'd4);
    step();
    #3 rst = 1'b0;
    #1;
    checks++;
    if (unlocked !== 1'b0 || pos !== 2'd0) begin
      errors++;
      $display("FAIL async_reset_open unl=%b pos=%0d exp unl=0 pos=0", unlocked, pos);
    end
    rst = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_correct_entry();
    test_wrong_first();
    test_lockout();
    test_abort();
    test_early_relock();
    test_reset_mid_entry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/combo_lock_ctrl.md
# combo_lock_ctrl

Sequencing controller for the combination lock. It accepts one keypad digit per strobe and tracks the entry position with a wrapping digit-position counter. After the last digit it compares the whole entry against the stored code and drives the unlock and lockout outputs. It sits between the debounced keypad strobe logic and the lock actuator/indicator LEDs, and owns the position counter and its reset.

## Interface
- `DIGITS`, 4: number of digits per code; the position counter counts 0..DIGITS-1 and then wraps.
- `DIGIT_W`, 4: width of one digit.
- `CODE`, 16'h4321: stored code. Digit i, where i=0 is entered first, sits at `CODE[i*DIGIT_W +: DIGIT_W]`. The default therefore expects the sequence 1,2,3,4.
- `MAX_FAILS`, 3: consecutive failed entries that trigger lockout.
- `OPEN_CYCLES`, 16: clock cycles the lock stays open.
- `LOCKOUT_CYCLES`, 64: clock cycles of lockout.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe; a digit is present on `key_digit`.
- `key_digit`  in  DIGIT_W  digit value, sampled only when `key_valid`=1.
- `relock`  in  1  level; closes the lock or aborts a partial entry.
- `pos`  out  $clog2(DIGITS)  index of the next digit expected.
- `unlocked`  out  1  lock open.
- `fail_pulse`  out  1  one-cycle pulse for each rejected entry.
- `lockout`  out  1  keypad locked out.
- `fail_cnt`  out  $clog2(MAX_FAILS+1)  consecutive failures so far.

## Operation
- States:
  - IDLE: waiting for the first digit.
  - ENTRY: collecting the remaining digits.
  - CHECK: one cycle, evaluates the entry.
  - FAIL: one cycle, reports a rejection.
  - OPEN: lock open, timed.
  - LOCKOUT: keypad disabled, timed.
- Outputs are registered and decoded from state and counters (Moore).
- Reset value of every output: `pos`=0, `unlocked`=0, `fail_pulse`=0, `lockout`=0, `fail_cnt`=0. Reset also forces state IDLE and clears the sticky mismatch flag.
- Digit acceptance, in IDLE or ENTRY with `key_valid`=1:
  - Compare `key_digit` against the CODE slot at `pos`; any mismatch sets the sticky mismatch flag.
  - `pos` increments.
  - IDLE moves to ENTRY.
- Entry completion:
  - When a digit is accepted at `pos`=DIGITS-1, `pos` wraps to 0 and the state moves to CHECK.
  - A single-digit code (DIGITS=1) goes directly from IDLE to CHECK.
- CHECK:
  - Mismatch flag clear: go to OPEN and clear `fail_cnt`.
  - Mismatch flag set: increment `fail_cnt`. Go to LOCKOUT if the new count equals MAX_FAILS, otherwise go to FAIL.
  - The mismatch flag is cleared in either case.
- No early rejection: a wrong first digit still requires the full DIGITS entries before rejection, so the lock does not reveal which digit was wrong.
- FAIL: `fail_pulse`=1 for one cycle, then IDLE.
- OPEN:
  - `unlocked`=1 for OPEN_CYCLES cycles, then IDLE.
  - `relock`=1 returns to IDLE on the next edge.
  - `key_valid` is ignored.
- LOCKOUT:
  - `lockout`=1 for LOCKOUT_CYCLES cycles; `key_valid` and `relock` are ignored.
  - On exit, `fail_cnt` is cleared and the state returns to IDLE.
- `relock`=1 in IDLE or ENTRY: `pos` goes to 0, the mismatch flag clears, state IDLE. No failure is counted. `relock` takes priority over a simultaneous `key_valid`.
- `key_valid` in CHECK, FAIL, OPEN or LOCKOUT is dropped and not queued.
- Asynchronous reset mid-entry or mid-timer discards all progress immediately.

## Timing
- Edge N samples the final digit; the state is CHECK after edge N.
- Edge N+1 leaves CHECK:
  - On success, `unlocked`=1 after N+1 and stays high through edge N+1+OPEN_CYCLES, falling after that edge.
  - On failure, `fail_pulse`=1 for the cycle after N+1 only.
  - On the MAX_FAILS-th failure, `lockout`=1 from after N+1 for exactly LOCKOUT_CYCLES cycles. `fail_cnt` reads MAX_FAILS during lockout.
- `pos` updates on the same edge that samples `key_valid`.
- Back-to-back strobes, one per cycle, are accepted in IDLE and ENTRY.
- Timers use one down-counter of width $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1). It is loaded on entry to OPEN or LOCKOUT; the state exits when the counter reaches 1.

## Structure
- Shared package `combo_lock_pkg`: the state enum (IDLE, ENTRY, CHECK, FAIL, OPEN, LOCKOUT) and the default DIGITS and DIGIT_W constants.
- Sub-module `digit_pos_counter`, parameterised by DIGITS:
  - Inputs: `clk`, `rst`, `inc`, `clr`.
  - Outputs: `pos` and `last`, where `last`=1 when `pos`=DIGITS-1.
  - Wraps to 0 on increment at `last`; `clr` has priority over `inc`.
- Controller FSM, comparator, mismatch flag, fail counter and timer live in `combo_lock_ctrl`.

## Test plan
- Correct entry: reset, then digits 1,2,3,4 on consecutive cycles. Required:
  - `pos` reads 1,2,3,0.
  - `unlocked`=1 two edges after the last digit, held 16 cycles.
  - `fail_cnt`=0.
- Wrong first digit: enter 9,2,3,4. Required:
  - No rejection before the 4th digit.
  - `fail_pulse` one cycle, `fail_cnt`=1, `unlocked` stays 0.
- Lockout: three wrong entries. Required:
  - `lockout`=1 for 64 cycles.
  - Digits 1,2,3,4 entered during lockout are ignored.
  - After lockout, `fail_cnt`=0 and a correct entry unlocks.
- Abort: enter 1,2, assert `relock` on the same cycle as digit 3. Required: `pos`=0, no `fail_pulse`; then 1,2,3,4 unlocks.
- Early relock: `relock` at cycle 5 of OPEN. Required: `unlocked` falls after the next edge; keys during OPEN are not counted.
- Reset mid-entry: drive `rst`=0 asynchronously after digits 1,2. Required: all outputs return to reset values immediately; the next 3,4 do not unlock.
